// File: rtl/program_loader.sv
// Host-stream loader for the pipeline core: pairs instruction/data words and writes
// them into core memory with a setup/strobe/hold sequence, then releases the core.
module program_loader #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] instruction,
  output logic [ADDR_W-1:0] instructionAddress,
  output logic [WORD_W-1:0] data,
  output logic [ADDR_W-1:0] dataAddress,
  output logic              writeEnable,
  output logic              busy,
  output logic              cpu_run,
  output logic [ADDR_W:0]   pairs_written
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_I  = 3'd1,
    GET_D  = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;

  state_t            state, nextState;
  logic [ADDR_W-1:0] addr;
  logic              endFlag;
  logic              xfer;
  logic              startOk;

  // in_ready is a flop that mirrors GET_I/GET_D, so xfer has no input-to-output path
  assign xfer    = in_valid && in_ready;
  assign startOk = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = GET_I;
      GET_I:   if (xfer)  nextState = in_last ? SETUP : GET_D;
      GET_D:   if (xfer)  nextState = SETUP;
      SETUP:   nextState = STROBE;
      STROBE:  nextState = HOLD;
      HOLD:    nextState = endFlag ? DONE : GET_I;
      DONE:    if (start) nextState = GET_I;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b0;
      writeEnable <= 1'b0;
      busy        <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      in_ready    <= (nextState == GET_I) || (nextState == GET_D);
      writeEnable <= (nextState == STROBE);
      busy        <= (nextState != IDLE) && (nextState != DONE);
      cpu_run     <= (nextState == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction   <= '0;
      data          <= '0;
      addr          <= '0;
      endFlag       <= 1'b0;
      pairs_written <= '0;
    end else begin
      if (state == GET_I && xfer) begin
        instruction <= in_word;
        if (in_last) begin
          data    <= '0;
          endFlag <= 1'b1;
        end
      end
      // The last address forces the end flag so the counter never wraps onto pair 0
      if (state == GET_D && xfer) begin
        data <= in_word;
        if (in_last || addr == ADDR_LAST) endFlag <= 1'b1;
      end
      if (state == HOLD) begin
        pairs_written <= pairs_written + CNT_ONE;
        if (!endFlag) addr <= addr + ADDR_ONE;
      end
      if (startOk) begin
        addr          <= '0;
        pairs_written <= '0;
        endFlag       <= 1'b0;
      end
    end
  end

  assign instructionAddress = addr;
  assign dataAddress        = addr;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: records every writeEnable pulse and checks
// addresses, words, counters and status against hand-computed expectations.
module tb_program_loader;
  logic        clk, rst, start, in_valid, in_last;
  logic [31:0] in_word;
  logic        in_ready, writeEnable, busy, cpu_run;
  logic [31:0] instruction, data;
  logic [6:0]  instructionAddress, dataAddress;
  logic [7:0]  pairs_written;

  int vecs = 0;
  int errs = 0;

  logic [6:0]  qA[$];
  logic [6:0]  qDA[$];
  logic [31:0] qI[$];
  logic [31:0] qD[$];

  program_loader #(.ADDR_W(7), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_word(in_word),
    .in_last(in_last), .in_ready(in_ready), .instruction(instruction),
    .instructionAddress(instructionAddress), .data(data), .dataAddress(dataAddress),
    .writeEnable(writeEnable), .busy(busy), .cpu_run(cpu_run),
    .pairs_written(pairs_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // writeEnable is high for exactly one cycle, so one negedge sample per pulse
  always @(negedge clk) begin
    if (writeEnable) begin
      qA.push_back(instructionAddress);
      qDA.push_back(dataAddress);
      qI.push_back(instruction);
      qD.push_back(data);
    end
  end

  task automatic clear_log();
    qA.delete(); qDA.delete(); qI.delete(); qD.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    int n;
    n = 0;
    in_word = w; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    vecs++;
    if (!in_ready) begin
      errs++;
      $display("FAIL send_timeout word=%h in_ready=%b required 1", w, in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cpu_run && n < 100) begin @(posedge clk); #1; n++; end
    vecs++;
    if (cpu_run !== 1'b1) begin
      errs++;
      $display("FAIL done_timeout cpu_run=%b required 1", cpu_run);
    end
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if ({in_ready, writeEnable, busy, cpu_run} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags got=%b required 0000", {in_ready, writeEnable, busy, cpu_run});
    end
    vecs++;
    if (instruction !== 32'h0 || data !== 32'h0) begin
      errs++; $display("FAIL reset_words instr=%h data=%h required 0/0", instruction, data);
    end
    vecs++;
    if (instructionAddress !== 7'd0 || dataAddress !== 7'd0 || pairs_written !== 8'd0) begin
      errs++; $display("FAIL reset_addr ia=%0d da=%0d pw=%0d required 0", instructionAddress, dataAddress, pairs_written);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset busy=%b in_ready=%b required 0/0", busy, in_ready);
    end
  endtask

  task automatic test_basic_pair();
    clear_log();
    pulse_start();
    vecs++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL basic_get_i in_ready=%b busy=%b required 1/1", in_ready, busy);
    end
    send(32'h20010005, 1'b0);
    send(32'h0000000A, 1'b1);
    // Handshake edge N leaves us in SETUP; next edge is STROBE
    vecs++;
    if (writeEnable !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL basic_setup we=%b busy=%b required 0/1", writeEnable, busy);
    end
    @(posedge clk); #1;
    vecs++;
    if (writeEnable !== 1'b1) begin
      errs++; $display("FAIL basic_strobe we=%b required 1", writeEnable);
    end
    wait_done();
    vecs++;
    if (qA.size() != 1) begin
      errs++; $display("FAIL basic_pulses got=%0d required 1", qA.size());
    end else if (qA[0] !== 7'd0 || qDA[0] !== 7'd0 || qI[0] !== 32'h20010005 || qD[0] !== 32'hA) begin
      errs++; $display("FAIL basic_write a=%0d da=%0d i=%h d=%h required 0/0/20010005/0000000a", qA[0], qDA[0], qI[0], qD[0]);
    end
    vecs++;
    if (pairs_written !== 8'd1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL basic_done pw=%0d busy=%b rdy=%b required 1/0/0", pairs_written, busy, in_ready);
    end
  endtask

  task automatic test_odd_length();
    clear_log();
    pulse_start();
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b1);
    wait_done();
    vecs++;
    if (qA.size() != 2) begin
      errs++; $display("FAIL odd_pulses got=%0d required 2", qA.size());
    end else begin
      vecs++;
      if (qA[0] !== 7'd0 || qI[0] !== 32'h11 || qD[0] !== 32'h22) begin
        errs++; $display("FAIL odd_pair0 a=%0d i=%h d=%h required 0/11/22", qA[0], qI[0], qD[0]);
      end
      vecs++;
      if (qA[1] !== 7'd1 || qDA[1] !== 7'd1 || qI[1] !== 32'h33 || qD[1] !== 32'h0) begin
        errs++; $display("FAIL odd_pair1 a=%0d i=%h d=%h required 1/33/0", qA[1], qI[1], qD[1]);
      end
    end
    vecs++;
    if (pairs_written !== 8'd2) begin
      errs++; $display("FAIL odd_count pw=%0d required 2", pairs_written);
    end
  endtask

  task automatic test_reload();
    clear_log();
    pulse_start();
    vecs++;
    if (cpu_run !== 1'b0 || busy !== 1'b1 || pairs_written !== 8'd0 || instructionAddress !== 7'd0) begin
      errs++; $display("FAIL reload_start run=%b busy=%b pw=%0d a=%0d required 0/1/0/0", cpu_run, busy, pairs_written, instructionAddress);
    end
    send(32'h55, 1'b0);
    send(32'h66, 1'b1);
    wait_done();
    vecs++;
    if (qA.size() != 1 || qA[0] !== 7'd0 || qI[0] !== 32'h55 || qD[0] !== 32'h66) begin
      errs++; $display("FAIL reload_write n=%0d required one pulse 0/55/66", qA.size());
    end
  endtask

  task automatic test_capacity();
    int accepted, n, bad;
    accepted = 0; bad = 0;
    clear_log();
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      in_word = i; in_last = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!in_ready && !cpu_run && n < 50) begin @(posedge clk); #1; n++; end
      if (cpu_run || !in_ready) break;
      @(posedge clk); #1;
      accepted++;
    end
    in_valid = 1'b0;
    vecs++;
    if (accepted != 256 || cpu_run !== 1'b1) begin
      errs++; $display("FAIL cap_accepted words=%0d run=%b required 256/1", accepted, cpu_run);
    end
    vecs++;
    if (qA.size() != 128) begin
      errs++; $display("FAIL cap_pulses got=%0d required 128", qA.size());
    end else begin
      for (int k = 0; k < 128; k++)
        if (qA[k] !== k[6:0] || qDA[k] !== k[6:0] || qI[k] !== 2*k || qD[k] !== 2*k+1) bad++;
      vecs++;
      if (bad != 0) begin
        errs++; $display("FAIL cap_sequence bad_entries=%0d required 0", bad);
      end
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (in_ready !== 1'b0 || pairs_written !== 8'd128 || qA.size() != 128) begin
      errs++; $display("FAIL cap_after rdy=%b pw=%0d pulses=%0d required 0/128/128", in_ready, pairs_written, qA.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    int bad;
    bad = 0;
    clear_log();
    pulse_start();
    send(32'hA0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b1 || writeEnable !== 1'b0 || instruction !== 32'hA0 || busy !== 1'b1) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++; $display("FAIL bp_gap_hold bad_cycles=%0d required 0", bad);
    end
    pulse_start();
    vecs++;
    if (in_ready !== 1'b1 || pairs_written !== 8'd0) begin
      errs++; $display("FAIL bp_start_ignored rdy=%b pw=%0d required 1/0", in_ready, pairs_written);
    end
    send(32'hA1, 1'b0);
    pulse_start();
    vecs++;
    if (writeEnable !== 1'b1 || instruction !== 32'hA0 || data !== 32'hA1) begin
      errs++; $display("FAIL bp_strobe we=%b i=%h d=%h required 1/a0/a1", writeEnable, instruction, data);
    end
    @(posedge clk); #1;
    vecs++;
    if (writeEnable !== 1'b0 || instruction !== 32'hA0 || data !== 32'hA1 || instructionAddress !== 7'd0) begin
      errs++; $display("FAIL bp_hold we=%b i=%h d=%h a=%0d required 0/a0/a1/0", writeEnable, instruction, data, instructionAddress);
    end
    repeat (3) @(posedge clk);
    #1;
    send(32'hB0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(32'hB1, 1'b0);
    send(32'hC0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send(32'hC1, 1'b1);
    wait_done();
    vecs++;
    if (qA.size() != 3) begin
      errs++; $display("FAIL bp_pulses got=%0d required 3", qA.size());
    end else begin
      vecs++;
      if (qA[0] !== 7'd0 || qA[1] !== 7'd1 || qA[2] !== 7'd2 ||
          qI[1] !== 32'hB0 || qD[1] !== 32'hB1 || qI[2] !== 32'hC0 || qD[2] !== 32'hC1) begin
        errs++; $display("FAIL bp_sequence a=%0d,%0d,%0d i2=%h d2=%h required 0,1,2 c0/c1", qA[0], qA[1], qA[2], qI[2], qD[2]);
      end
    end
    vecs++;
    if (pairs_written !== 8'd3) begin
      errs++; $display("FAIL bp_count pw=%0d required 3", pairs_written);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    send(32'h1, 1'b0); send(32'h2, 1'b0);
    send(32'h3, 1'b0); send(32'h4, 1'b0);
    send(32'h5, 1'b0); send(32'h6, 1'b0);
    @(posedge clk); #1;
    vecs++;
    if (writeEnable !== 1'b1 || instructionAddress !== 7'd2) begin
      errs++; $display("FAIL rml_in_strobe we=%b a=%0d required 1/2", writeEnable, instructionAddress);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (writeEnable !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || pairs_written !== 8'd0) begin
      errs++; $display("FAIL rml_async we=%b busy=%b rdy=%b pw=%0d required 0/0/0/0", writeEnable, busy, in_ready, pairs_written);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vecs++;
    if (qA.size() != 2) begin
      errs++; $display("FAIL rml_pulses got=%0d required 2", qA.size());
    end
    clear_log();
    pulse_start();
    send(32'h77, 1'b0);
    send(32'h88, 1'b1);
    wait_done();
    vecs++;
    if (qA.size() != 1 || qA[0] !== 7'd0 || qI[0] !== 32'h77 || qD[0] !== 32'h88 || pairs_written !== 8'd1) begin
      errs++; $display("FAIL rml_reload n=%0d pw=%0d required one pulse at 0, pw 1", qA.size(), pairs_written);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
    test_reset();
    test_basic_pair();
    test_odd_length();
    test_reload();
    test_capacity();
    test_back_pressure();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
